// File: rtl/score_keeper_pkg.sv
// Shared pong constants: field/ball/paddle geometry used by ball stage, renderer and scoring,
// plus the score_keeper state encoding.
package score_keeper_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_W   = 8;
  localparam int PADDLE_H   = 64;
  localparam int PADDLE_X_L = 16;
  localparam int PADDLE_X_R = H_ACTIVE - 16 - PADDLE_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    PAUSE     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;
endpackage

// File: rtl/score_keeper_goal_detect.sv
// Edge-goal detection with a re-arm latch: one goal per edge visit, re-armed only when
// the ball is back at centre. Combinational goal outputs, registered armed flag.
module goal_detect #(
  parameter int H_ACTIVE     = 640,
  parameter int LEFT_GOAL_X  = 1,
  parameter int RIGHT_GOAL_X = 637
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ball_x,
  input  logic       accept,
  output logic       goal_l,
  output logic       goal_r
);
  localparam logic [9:0] CENTRE_X = 10'(H_ACTIVE / 2);
  localparam logic [9:0] LEFT_X   = 10'(LEFT_GOAL_X);
  localparam logic [9:0] RIGHT_X  = 10'(RIGHT_GOAL_X);

  logic armed;

  assign goal_l = armed && (ball_x <= LEFT_X);
  assign goal_r = armed && (ball_x >= RIGHT_X);

  // A centre position can never be a goal, so clear and set never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b1;
    end else if (accept) begin
      armed <= 1'b0;
    end else if (ball_x == CENTRE_X) begin
      armed <= 1'b1;
    end
  end
endmodule

// File: rtl/score_keeper.sv
// Pong scoring: goal detection, score counters and IDLE/PLAY/PAUSE/GAME_OVER control.
// Goal to score/pulse/ball_enable change is one cycle; all outputs are registered.
module score_keeper #(
  parameter int H_ACTIVE     = score_keeper_pkg::H_ACTIVE,
  parameter int LEFT_GOAL_X  = 1,
  parameter int RIGHT_GOAL_X = 637,
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ball_x,
  input  logic       start,
  output logic       ball_enable,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       point_p1,
  output logic       point_p2,
  output logic       game_over,
  output logic       winner
);
  import score_keeper_pkg::*;

  localparam int         CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0] WIN      = 4'(WIN_SCORE);

  state_t           state;
  logic [CNT_W-1:0] pause_cnt;
  logic             start_d;
  logic             start_rise;
  logic             goal_l;
  logic             goal_r;
  logic             accept;

  assign start_rise = start && !start_d;
  assign accept     = (state == PLAY) && (goal_l || goal_r);

  goal_detect #(
    .H_ACTIVE    (H_ACTIVE),
    .LEFT_GOAL_X (LEFT_GOAL_X),
    .RIGHT_GOAL_X(RIGHT_GOAL_X)
  ) u_goal_detect (
    .clk   (clk),
    .reset (reset),
    .ball_x(ball_x),
    .accept(accept),
    .goal_l(goal_l),
    .goal_r(goal_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pause_cnt   <= '0;
      start_d     <= 1'b0;
      ball_enable <= 1'b0;
      p1_score    <= 4'd0;
      p2_score    <= 4'd0;
      point_p1    <= 1'b0;
      point_p2    <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      start_d  <= start;
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= PLAY;
            ball_enable <= 1'b1;
          end
        end
        PLAY: begin
          // Left goal takes priority should the two goal windows ever overlap.
          if (goal_l || goal_r) begin
            ball_enable <= 1'b0;
            if (goal_l) begin
              p2_score <= p2_score + 4'd1;
              point_p2 <= 1'b1;
            end else begin
              p1_score <= p1_score + 4'd1;
              point_p1 <= 1'b1;
            end
            if ((goal_l ? p2_score : p1_score) + 4'd1 == WIN) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= goal_l;
            end else begin
              state     <= PAUSE;
              pause_cnt <= '0;
            end
          end
        end
        PAUSE: begin
          if (pause_cnt == CNT_LAST) begin
            state       <= PLAY;
            ball_enable <= 1'b1;
          end else begin
            pause_cnt <= pause_cnt + CNT_W'(1);
          end
        end
        GAME_OVER: begin
          if (start_rise) begin
            state       <= PLAY;
            ball_enable <= 1'b1;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_keeper.sv
// Directed and randomized rallies against a rally-level score model for score_keeper.
module tb_score_keeper;
  localparam int PC = 10;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] ball_x;
  logic       ball_enable;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       point_p1;
  logic       point_p2;
  logic       game_over;
  logic       winner;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses1  = 0;
  int pulses2  = 0;

  score_keeper #(
    .H_ACTIVE    (640),
    .LEFT_GOAL_X (1),
    .RIGHT_GOAL_X(637),
    .WIN_SCORE   (WS),
    .PAUSE_CYCLES(PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ball_x     (ball_x),
    .start      (start),
    .ball_enable(ball_enable),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .point_p1   (point_p1),
    .point_p2   (point_p2),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge, tallying point pulses.
  task automatic step();
    @(posedge clk);
    #1;
    pulses1 += int'(point_p1);
    pulses2 += int'(point_p2);
  endtask

  function automatic logic [9:0] rand_mid();
    logic [9:0] x;
    x = 10'($urandom_range(2, 636));
    if (x == 10'd320) x = 10'd321;
    return x;
  endfunction

  initial begin
    int bad, lows, side, m1, m2, w;

    reset  = 1'b1;
    start  = 1'b0;
    ball_x = 10'd320;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", ball_enable, 0);
    chk("rst_p1", p1_score, 0);
    chk("rst_p2", p2_score, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_points", {point_p1, point_p2, winner}, 0);

    // Idle without start: nothing moves.
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (ball_enable !== 1'b0 || p1_score !== 4'd0 || p2_score !== 4'd0 || game_over !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_enable", ball_enable, 1);

    // Ball runs to the left edge and sits there.
    pulses1 = 0; pulses2 = 0; lows = 0;
    for (int x = 320; x >= 0; x--) begin
      ball_x = 10'(x);
      step();
      lows += int'(!ball_enable);
      if (x == 1) begin
        chk("left_goal_pulse_latency", point_p2, 1);
        chk("left_goal_score", p2_score, 1);
        chk("left_goal_enable_drop", ball_enable, 0);
      end
    end
    repeat ($urandom_range(40, 60)) begin
      step();
      lows += int'(!ball_enable);
    end
    chk("left_hold_p2_pulses", pulses2, 1);
    chk("left_hold_p1_pulses", pulses1, 0);
    chk("left_hold_p2_score", p2_score, 1);
    chk("pause_low_cycles", lows, PC);
    chk("pause_end_enable", ball_enable, 1);

    // Right goals, with re-arming only at centre.
    pulses1 = 0; pulses2 = 0;
    ball_x = 10'd320; step();
    ball_x = 10'd637; step();
    chk("right_goal_pulse", point_p1, 1);
    chk("right_goal_score", p1_score, 1);
    repeat (PC + 2) step();
    chk("right_pause_end_enable", ball_enable, 1);
    repeat ($urandom_range(1, 6)) begin
      ball_x = rand_mid(); step();
    end
    ball_x = 10'd637;
    repeat (5) step();
    chk("no_rearm_without_centre", p1_score, 1);
    chk("no_rearm_pulses", pulses1, 1);
    ball_x = 10'd320; step();
    ball_x = 10'd637; step();
    chk("second_right_goal_score", p1_score, 2);
    chk("second_right_goal_pulse", point_p1, 1);
    repeat (PC + 2) step();
    chk("second_right_enable", ball_enable, 1);

    // Winning point.
    ball_x = 10'd320; step();
    ball_x = 10'd637; step();
    chk("win_p1_score", p1_score, WS);
    chk("win_game_over", game_over, 1);
    chk("win_winner", winner, 0);
    chk("win_enable", ball_enable, 0);
    ball_x = 10'd320; step();
    ball_x = 10'd637;
    repeat (5) step();
    chk("frozen_p1_score", p1_score, WS);
    chk("frozen_p1_pulses", pulses1, 3);
    chk("frozen_game_over", game_over, 1);

    // Restart from game over, then hold start high.
    ball_x = 10'd320;
    start = 1'b1;
    step();
    chk("restart_scores", {p1_score, p2_score}, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_enable", ball_enable, 1);
    bad = 0;
    repeat (20) begin
      step();
      if (ball_enable !== 1'b1 || game_over !== 1'b0 || p1_score !== 4'd0 || p2_score !== 4'd0) bad++;
    end
    chk("start_held_bad_cycles", bad, 0);
    start = 1'b0;

    // Reset in the middle of a pause.
    ball_x = 10'd0; step();
    chk("pre_reset_p2", p2_score, 1);
    ball_x = 10'd320;
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("midpause_reset_scores", {p1_score, p2_score}, 0);
    chk("midpause_reset_enable", ball_enable, 0);
    chk("midpause_reset_flags", {game_over, winner, point_p1, point_p2}, 0);
    repeat (2) step();
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      bad += int'(ball_enable !== 1'b0);
    end
    chk("post_reset_idle", bad, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("post_reset_start", ball_enable, 1);

    // Random rallies against a rally-level model.
    m1 = 0; m2 = 0;
    for (int r = 0; r < 14; r++) begin
      side = int'($urandom_range(0, 1));
      pulses1 = 0; pulses2 = 0;
      ball_x = 10'd320; step();
      repeat ($urandom_range(0, 4)) begin
        ball_x = rand_mid(); step();
      end
      ball_x = (side == 1) ? 10'($urandom_range(0, 1)) : 10'($urandom_range(637, 1023));
      repeat ($urandom_range(1, 15)) step();
      ball_x = 10'd320;
      w = 0;
      while (!ball_enable && !game_over && w < 4 * PC) begin
        step();
        w++;
      end
      chk("rally_resume", ball_enable | game_over, 1);
      if (side == 1) m2++; else m1++;
      chk("rally_p1_score", p1_score, m1);
      chk("rally_p2_score", p2_score, m2);
      chk("rally_p1_pulses", pulses1, (side == 1) ? 0 : 1);
      chk("rally_p2_pulses", pulses2, (side == 1) ? 1 : 0);
      if (m1 == WS || m2 == WS) begin
        chk("rally_game_over", game_over, 1);
        chk("rally_winner", winner, (m2 == WS) ? 1 : 0);
        start = 1'b1; step();
        start = 1'b0; step();
        chk("rally_restart_scores", {p1_score, p2_score}, 0);
        chk("rally_restart_enable", ball_enable, 1);
        m1 = 0; m2 = 0;
      end else begin
        chk("rally_not_over", game_over, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits downstream of the ball-motion stage. It consumes the ball X position and detects goals at the left and right field edges.
- Keeps both players' scores, runs the serve, pause and game-over state machine, and drives ball_enable back to the ball stage's active-low hold input.
- Score and winner outputs feed the pixel/overlay renderer.

Parameters:
- H_ACTIVE, 640, visible width in pixels; the ball re-serves at H_ACTIVE/2.
- LEFT_GOAL_X, 1, ball_x <= this value is a left-edge goal (player 2 scores).
- RIGHT_GOAL_X, 637, ball_x >= this value is a right-edge goal (player 1 scores).
- WIN_SCORE, 7, score that ends the game; legal range 1..15.
- PAUSE_CYCLES, 50_000_000, clk cycles the ball is held after a point (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ball_x  in  10  current ball X from the ball stage (changes on the slow tick)
- start  in  1  synchronous level (e.g. debounced button); only the rising edge acts
- ball_enable  out  1  1 = ball may move; 0 = ball held at centre
- p1_score  out  4  player-1 score, 0..WIN_SCORE
- p2_score  out  4  player-2 score, 0..WIN_SCORE
- point_p1  out  1  one-cycle pulse when player 1 scores
- point_p2  out  1  one-cycle pulse when player 2 scores
- game_over  out  1  high while in GAME_OVER
- winner  out  1  0 = player 1, 1 = player 2; valid only while game_over = 1

Behaviour:
- All state is reset asynchronously while reset = 1. Values in reset:
  - state = IDLE
  - scores = 0
  - pause counter = 0
  - armed = 1
  - start_d = 0
  - all outputs = 0
- start edge: start_d is a registered copy of start; start_rise = start & ~start_d.
- armed flag (updates in every state):
  - cleared on the cycle a goal is accepted;
  - set when ball_x == H_ACTIVE/2.
  - Guarantees exactly one point per edge hit, even if ball_x sits at the edge for many clk cycles.
- goal_l = armed & (ball_x <= LEFT_GOAL_X); goal_r = armed & (ball_x >= RIGHT_GOAL_X). Both are unsigned 10-bit compares. They are mutually exclusive by value; if both parameters were mis-set, goal_l wins.
- FSM, one state register, all transitions on posedge clk:
  - IDLE: ball_enable = 0. On start_rise -> PLAY.
  - PLAY: ball_enable = 1.
    - goal_r: p1_score += 1, point_p1 = 1 next cycle.
    - goal_l: p2_score += 1, point_p2 = 1 next cycle.
    - If the incremented score == WIN_SCORE -> GAME_OVER, with winner latched in the same cycle. Otherwise -> PAUSE, counter = 0.
  - PAUSE: ball_enable = 0. Counter increments each cycle; at PAUSE_CYCLES-1 -> PLAY. Goals are ignored.
  - GAME_OVER: ball_enable = 0, game_over = 1, scores frozen. On start_rise: scores cleared, winner cleared -> PLAY.
- start_rise in PLAY or PAUSE has no effect.
- Latencies:
  - goal-qualifying ball_x to score/pulse update: 1 cycle (registered);
  - ball_enable falls 1 cycle after the goal;
  - ball_enable rises on the cycle after the last pause count.
- Scores never exceed WIN_SCORE, so there is no wrap. The increment is 4-bit and saturating by construction.
- The pause counter width is $clog2(PAUSE_CYCLES); PAUSE_CYCLES >= 1.
- Reset mid-operation, in any state: immediate return to IDLE with zeroed scores; pulses are dropped.

Decomposition:
- Shared pong package holds:
  - H_ACTIVE / V_ACTIVE and ball/paddle geometry constants, also used by the ball stage and the renderer;
  - the state encoding (IDLE = 0, PLAY = 1, PAUSE = 2, GAME_OVER = 3).
- One natural sub-module: goal_detect. It holds the armed flag and the edge compares, taking ball_x in and giving goal_l/goal_r out. The FSM and counters stay in score_keeper.

Test Plan:
- Reset, then reset deassert with start = 0 -> ball_enable = 0, scores 0/0, game_over = 0, held for 100 cycles.
- start pulse, then ball_x steps 320,319,...,0 and holds 0 for 50 cycles -> p2_score = 1 exactly once, one point_p2 pulse, ball_enable = 0 for PAUSE_CYCLES (bench sets 10), then 1.
- From PLAY, ball_x goes 320 -> 637 -> 320 -> 637 -> p1_score = 2. A second goal is not accepted until ball_x returns to 320.
- WIN_SCORE = 3 with three right-edge goals -> p1_score = 3, game_over = 1, winner = 0, ball_enable = 0. A further ball_x = 637 leaves the score unchanged.
- In GAME_OVER, start rising edge -> scores 0/0, game_over = 0, ball_enable = 1 next cycle. Holding start high gives no second action.
- Reset asserted mid-PAUSE (counter = 5) -> immediate IDLE, scores 0/0. After release, start is needed to play.
